// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: state encoding, next-PC select encoding and the fixed constants
// used by fetch_unit and fetch_pc_next.
// Ports: none (package).
// Optional feature macro used elsewhere in the slice: FETCH_PERF_CNT_EN.

package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_INIT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  localparam logic [7:0]  PC_STEP       = 8'd2;
  localparam logic [15:0] HALT_WORD     = 16'h0000;
  localparam logic [7:0]  PC_ALIGN_MASK = 8'hFE;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - combinational next-PC select for the fetch stage
//
// Purpose: chooses hold / PC+2 / redirect target, forcing halfword alignment
// on the redirect target.
// Ports:
//   pc_i      current PC
//   sel_i     select: PC_HOLD, PC_INC, PC_REDIRECT
//   target_i  redirect byte address (bit 0 ignored)
//   pc_next_o next PC value

module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [7:0] pc_i,
  input  pc_sel_e    sel_i,
  input  logic [7:0] target_i,
  output logic [7:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_i;
    case (sel_i)
      PC_INC:      pc_next_o = pc_i + PC_STEP;  // 8-bit wrap is intended
      PC_REDIRECT: pc_next_o = target_i & PC_ALIGN_MASK;
      default:     pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, redirect and halt
//
// Purpose: owns the PC, addresses the instruction RAM, registers the returned
// word into the IF/ID register and hands it to decode over valid/ready.
// Waits INIT_CYCLES after reset for the RAM load, halts on the all-zero word,
// and leaves HALT only on a branch redirect or reset.
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   IADDR                 RAM byte address (== PC)
//   IDATA                 RAM word, combinational from IADDR
//   ID_VALID/ID_READY     handshake to decode
//   ID_INSTR/ID_PC        registered instruction and its byte address
//   BR_TAKEN/BR_TARGET    single-cycle redirect from execute
//   HALTED                high in HALT state
//   PERF_FETCHED/PERF_STALLED  only when FETCH_PERF_CNT_EN is defined

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [7:0]  IADDR,
  input  logic [15:0] IDATA,
  output logic        ID_VALID,
  input  logic        ID_READY,
  output logic [15:0] ID_INSTR,
  output logic [7:0]  ID_PC,
  input  logic        BR_TAKEN,
  input  logic [7:0]  BR_TARGET,
  output logic        HALTED
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] PERF_FETCHED,
  output logic [15:0] PERF_STALLED
`endif
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [15:0]  id_instr_q, id_instr_d;
  logic [7:0]   id_pc_q, id_pc_d;
  pc_sel_e      pc_sel;
  logic         fire;

  fetch_pc_next u_pc_next (
    .pc_i      (pc_q),
    .sel_i     (pc_sel),
    .target_i  (BR_TARGET),
    .pc_next_o (pc_d)
  );

  assign fire = !id_valid_q || ID_READY;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    pc_sel     = PC_HOLD;

    // Redirect wins over everything: flush IF/ID, skip this cycle's capture.
    if (BR_TAKEN) begin
      pc_sel     = PC_REDIRECT;
      id_valid_d = 1'b0;
      if (state_q == FETCH_HALT) state_d = FETCH_RUN;
    end

    case (state_q)
      FETCH_INIT: begin
        if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        // >= so a redirect on the final INIT cycle only delays the exit.
        if (!BR_TAKEN && cnt_q >= INIT_LAST) state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (!BR_TAKEN && fire) begin
          if (IDATA == HALT_WORD) begin
            id_valid_d = 1'b0;
            state_d    = FETCH_HALT;
          end else begin
            id_instr_d = IDATA;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_sel     = PC_INC;
          end
        end
      end
      FETCH_HALT: id_valid_d = 1'b0;
      default:    state_d = FETCH_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= FETCH_INIT;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= 16'h0000;
      id_pc_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign IADDR    = pc_q;
  assign ID_VALID = id_valid_q;
  assign ID_INSTR = id_instr_q;
  assign ID_PC    = id_pc_q;
  assign HALTED   = (state_q == FETCH_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched_q, perf_stalled_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_fetched_q <= 16'h0000;
      perf_stalled_q <= 16'h0000;
    end else begin
      if (id_valid_q && ID_READY && perf_fetched_q != 16'hFFFF)
        perf_fetched_q <= perf_fetched_q + 16'd1;
      if (id_valid_q && !ID_READY && perf_stalled_q != 16'hFFFF)
        perf_stalled_q <= perf_stalled_q + 16'd1;
    end
  end

  assign PERF_FETCHED = perf_fetched_q;
  assign PERF_STALLED = perf_stalled_q;
`endif

endmodule
